// File: rtl/reg_file_sb.sv
// reg_file_sb: 2^ADDR_W x WIDTH register file with two combinational read ports and a pending scoreboard.
// Optional WRITE_BYPASS_EN forwards same-cycle writeback data and readiness to the read ports.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_rdy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_rdy_b,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, iss_ok, inc, dec;
  logic [ADDR_W-1:0] ra [2];
  logic [WIDTH-1:0]  rd [2];
  logic [1:0]        rr;
  assign wr_ok  = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);
  // An issue to the register being written on the same edge keeps it pending.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    inc   = iss_ok && !pend_q[iss_addr];
    dec   = wr_ok && pend_q[wr_addr] && !(iss_ok && iss_addr == wr_addr);
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  assign ra[0] = rd_addr_a;
  assign ra[1] = rd_addr_b;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero, byp;
    assign zero = ZERO_REG != 0 && ra[p] == '0;
`ifdef WRITE_BYPASS_EN
    assign byp = wr_ok && wr_addr == ra[p];
`else
    assign byp = 1'b0;
`endif
    assign rd[p] = byp ? wr_data : zero ? '0 : mem_q[ra[p]];
    assign rr[p] = byp ? !(iss_ok && iss_addr == ra[p]) : zero | ~pend_q[ra[p]];
  end
  assign rd_data_a = rd[0];
  assign rd_data_b = rd[1];
  assign rd_rdy_a  = rr[0];
  assign rd_rdy_b  = rr[1];
  assign pend_cnt  = cnt_q;
endmodule
